// File: rtl/cart_mem_arbiter.sv
// Arbitrates requesters A and B onto one synchronous memory port with a fixed 3-cycle read latency.
// A has priority, but B is guaranteed a slot after MAX_A_BURST consecutive A grants.
module cart_mem_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int MAX_A_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int STREAK_W = (MAX_A_BURST < 1) ? 1 : $clog2(MAX_A_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_A_BURST);
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic [STREAK_W-1:0] streak_q, streak_d;

    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;

    logic tag1_valid_q, tag1_valid_d;
    logic tag1_src_q, tag1_src_d;
    logic tag2_valid_q, tag2_valid_d;
    logic tag2_src_q, tag2_src_d;

    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    // A starved B for MAX_A_BURST grants: B wins this cycle even if A is asking.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (b_req && (streak_q == STREAK_MAX)) begin
                b_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!b_req || b_gnt) begin
            streak_d = '0;
        end else if (a_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_comb begin
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mem_cs_d        = 1'b0;
        mem_write_d     = 1'b0;
        if (a_gnt) begin
            mem_address_d   = a_addr;
            mem_writedata_d = a_wdata;
            mem_cs_d        = 1'b1;
            mem_write_d     = a_write;
        end else if (b_gnt) begin
            mem_address_d   = b_addr;
            mem_writedata_d = b_wdata;
            mem_cs_d        = 1'b1;
            mem_write_d     = b_write;
        end
    end

    // Tag stage 1 lines up with the issued address, stage 2 with the memory's readdata.
    always_comb begin
        tag1_valid_d = (a_gnt && !a_write) || (b_gnt && !b_write);
        tag1_src_d   = b_gnt ? SRC_B : SRC_A;
        tag2_valid_d = tag1_valid_q;
        tag2_src_d   = tag1_src_q;
    end

    always_comb begin
        a_rvalid_d = tag2_valid_q && (tag2_src_q == SRC_A);
        b_rvalid_d = tag2_valid_q && (tag2_src_q == SRC_B);
        a_rdata_d  = a_rvalid_d ? mem_readdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_readdata : b_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q        <= '0;
            mem_address_q   <= '0;
            mem_cs_q        <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
            tag1_valid_q    <= 1'b0;
            tag1_src_q      <= SRC_A;
            tag2_valid_q    <= 1'b0;
            tag2_src_q      <= SRC_A;
            a_rvalid_q      <= 1'b0;
            b_rvalid_q      <= 1'b0;
            a_rdata_q       <= '0;
            b_rdata_q       <= '0;
        end else begin
            streak_q        <= streak_d;
            mem_address_q   <= mem_address_d;
            mem_cs_q        <= mem_cs_d;
            mem_write_q     <= mem_write_d;
            mem_writedata_q <= mem_writedata_d;
            tag1_valid_q    <= tag1_valid_d;
            tag1_src_q      <= tag1_src_d;
            tag2_valid_q    <= tag2_valid_d;
            tag2_src_q      <= tag2_src_d;
            a_rvalid_q      <= a_rvalid_d;
            b_rvalid_q      <= b_rvalid_d;
            a_rdata_q       <= a_rdata_d;
            b_rdata_q       <= b_rdata_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_clken      = !reset;

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Testbench for cart_mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of grants, issue and read returns.
module tb_cart_mem_arbiter;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 8;
    localparam int MAX_A_BURST = 4;
    localparam int MEM_WORDS   = 1 << ADDR_W;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              a_req   = 1'b0;
    logic              a_write = 1'b0;
    logic [ADDR_W-1:0] a_addr  = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              b_req   = 1'b0;
    logic              b_write = 1'b0;
    logic [ADDR_W-1:0] b_addr  = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    cart_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_A_BURST(MAX_A_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
        case (a)
            13'h0123: return 8'h5A;
            13'h0000: return 8'h11;
            13'h1FFF: return 8'hEE;
            default:  return a[7:0] ^ a[12:5];
        endcase
    endfunction

    // Memory port 2: synchronous RAM, readdata one cycle after the address.
    logic [DATA_W-1:0] env_mem     [MEM_WORDS];
    bit                env_written [MEM_WORDS];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                env_mem[mem_address]     <= mem_writedata;
                env_written[mem_address] <= 1'b1;
            end
            mem_readdata <= env_written[mem_address] ? env_mem[mem_address] : preload(mem_address);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: grant decision from the priority rules, a shadow memory updated at
    // grant time, and read returns scheduled 3 cycles after their grant.
    logic [DATA_W-1:0] ref_mem     [MEM_WORDS];
    bit                ref_written [MEM_WORDS];
    int                streak   = 0;
    int                cyc      = 0;
    bit                model_ok = 1'b0;
    bit                exp_cs   = 1'b0;
    bit                exp_we   = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wd   = '0;
    logic [DATA_W-1:0] exp_ard  = '0;
    logic [DATA_W-1:0] exp_brd  = '0;
    bit                ev_v   [4];
    bit                ev_src [4];
    logic [DATA_W-1:0] ev_d   [4];

    function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
        return ref_written[a] ? ref_mem[a] : preload(a);
    endfunction

    always @(negedge clk) begin : model
        int                slot;
        int                fut;
        bit                e_arv, e_brv, g_a, g_b;
        slot  = cyc % 4;
        e_arv = ev_v[slot] && !ev_src[slot];
        e_brv = ev_v[slot] && ev_src[slot];
        if (e_arv) exp_ard = ev_d[slot];
        if (e_brv) exp_brd = ev_d[slot];
        ev_v[slot] = 1'b0;
        if (model_ok) begin
            checkOutput("m_a_rvalid", 32'(a_rvalid), 32'(e_arv));
            checkOutput("m_b_rvalid", 32'(b_rvalid), 32'(e_brv));
            checkOutput("m_a_rdata", 32'(a_rdata), 32'(exp_ard));
            checkOutput("m_b_rdata", 32'(b_rdata), 32'(exp_brd));
            checkOutput("m_mem_cs", 32'(mem_chipselect), 32'(exp_cs));
            checkOutput("m_mem_write", 32'(mem_write), 32'(exp_we));
            if (exp_cs) begin
                checkOutput("m_mem_address", 32'(mem_address), 32'(exp_addr));
                checkOutput("m_mem_wdata", 32'(mem_writedata), 32'(exp_wd));
            end
        end
        checkOutput("m_mem_clken", 32'(mem_clken), 32'(!reset));
        g_a = 1'b0;
        g_b = 1'b0;
        if (!reset) begin
            if (b_req && streak >= MAX_A_BURST) g_b = 1'b1;
            else if (a_req)                     g_a = 1'b1;
            else if (b_req)                     g_b = 1'b1;
        end
        checkOutput("m_a_gnt", 32'(a_gnt), 32'(g_a));
        checkOutput("m_b_gnt", 32'(b_gnt), 32'(g_b));
        if (reset) begin
            streak   = 0;
            exp_cs   = 1'b0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_wd   = '0;
            exp_ard  = '0;
            exp_brd  = '0;
            for (int i = 0; i < 4; i++) ev_v[i] = 1'b0;
            model_ok = 1'b1;
        end else begin
            if (!b_req || g_b) streak = 0;
            else if (g_a && streak < MAX_A_BURST) streak = streak + 1;
            if (g_a || g_b) begin
                exp_cs   = 1'b1;
                exp_we   = g_a ? a_write : b_write;
                exp_addr = g_a ? a_addr : b_addr;
                exp_wd   = g_a ? a_wdata : b_wdata;
                if (exp_we) begin
                    ref_mem[exp_addr]     = exp_wd;
                    ref_written[exp_addr] = 1'b1;
                end else begin
                    fut         = (cyc + 3) % 4;
                    ev_v[fut]   = 1'b1;
                    ev_src[fut] = g_b;
                    ev_d[fut]   = refRead(exp_addr);
                end
            end else begin
                exp_cs = 1'b0;
                exp_we = 1'b0;
            end
        end
        cyc++;
    end

    // Inputs change just after the rising edge; returns at the following falling edge.
    task automatic applyStimulus(input bit r,
                                 input bit aq, input bit aw, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                 input bit bq, input bit bw, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        @(posedge clk);
        #1;
        reset   = r;
        a_req   = aq;
        a_write = aw;
        a_addr  = aa;
        a_wdata = ad;
        b_req   = bq;
        b_write = bw;
        b_addr  = ba;
        b_wdata = bd;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [ADDR_W-1:0] pickAddr();
        case ($urandom_range(3))
            0:       return ADDR_W'($urandom_range(3));
            1:       return 13'h1FFF - ADDR_W'($urandom_range(3));
            default: return ADDR_W'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit rst_next;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("rst_a_gnt", 32'(a_gnt), 32'd0);
        checkOutput("rst_mem_cs", 32'(mem_chipselect), 32'd0);
        checkOutput("rst_mem_clken", 32'(mem_clken), 32'd0);
        checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
        checkOutput("rst_a_rdata", 32'(a_rdata), 32'd0);

        // Single read, granted in the very first cycle out of reset.
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 1'b0, '0, '0);
        checkOutput("rd_a_gnt", 32'(a_gnt), 32'd1);
        checkOutput("rd_b_gnt", 32'(b_gnt), 32'd0);
        checkOutput("rd_clken", 32'(mem_clken), 32'd1);
        idle();
        checkOutput("rd_mem_cs", 32'(mem_chipselect), 32'd1);
        checkOutput("rd_mem_address", 32'(mem_address), 32'h0123);
        checkOutput("rd_mem_write", 32'(mem_write), 32'd0);
        idle();
        checkOutput("rd_early_rvalid", 32'(a_rvalid), 32'd0);
        idle();
        checkOutput("rd_a_rvalid", 32'(a_rvalid), 32'd1);
        checkOutput("rd_a_rdata", 32'(a_rdata), 32'h5A);
        idle();
        checkOutput("rd_rvalid_once", 32'(a_rvalid), 32'd0);
        checkOutput("rd_rdata_hold", 32'(a_rdata), 32'h5A);

        // Continuous contention: A,A,A,A,B repeating.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, ADDR_W'(i), 8'h00, 1'b1, 1'b0, ADDR_W'(100 + i), 8'h00);
            checkOutput("cont_a_gnt", 32'(a_gnt), 32'(i % 5 != 4));
            checkOutput("cont_b_gnt", 32'(b_gnt), 32'(i % 5 == 4));
        end
        for (int i = 0; i < 4; i++) idle();

        // Address boundary reads alternating between A and B.
        for (int i = 0; i < 12; i++) begin
            if (i < 8 && i % 2 == 0)  applyStimulus(1'b0, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, '0, '0);
            else if (i < 8)           applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 13'h1FFF, 8'h00);
            else                      idle();
            if (i >= 3 && i < 11) begin
                checkOutput("alt_a_rvalid", 32'(a_rvalid), 32'((i - 3) % 2 == 0));
                checkOutput("alt_b_rvalid", 32'(b_rvalid), 32'((i - 3) % 2 == 1));
                if ((i - 3) % 2 == 0) checkOutput("alt_a_rdata", 32'(a_rdata), 32'h11);
                else                  checkOutput("alt_b_rdata", 32'(b_rdata), 32'hEE);
            end
        end

        // B write immediately followed by an A read of the same word.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'h1FFF, 8'hC3);
        checkOutput("raw_b_gnt", 32'(b_gnt), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0, '0, '0);
        checkOutput("raw_a_gnt", 32'(a_gnt), 32'd1);
        idle();
        idle();
        idle();
        checkOutput("raw_a_rvalid", 32'(a_rvalid), 32'd1);
        checkOutput("raw_a_rdata", 32'(a_rdata), 32'hC3);
        checkOutput("raw_b_rvalid", 32'(b_rvalid), 32'd0);

        // Reset while two reads are in flight.
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0010, 8'h00, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0011, 8'h00, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 13'h0012, 8'h00, 1'b0, 1'b0, '0, '0);
        checkOutput("mrst_a_gnt", 32'(a_gnt), 32'd0);
        checkOutput("mrst_clken", 32'(mem_clken), 32'd0);
        idle();
        checkOutput("mrst_a_rvalid0", 32'(a_rvalid), 32'd0);
        checkOutput("mrst_mem_cs", 32'(mem_chipselect), 32'd0);
        checkOutput("mrst_mem_address", 32'(mem_address), 32'd0);
        checkOutput("mrst_a_rdata", 32'(a_rdata), 32'd0);
        idle();
        checkOutput("mrst_a_rvalid1", 32'(a_rvalid), 32'd0);

        // Streak clears when b_req drops for one cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 13'h0020, 8'h00, 1'b1, 1'b0, 13'h0030, 8'h00);
            checkOutput("stk_pre_a_gnt", 32'(a_gnt), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h0020, 8'h00, 1'b0, 1'b0, '0, '0);
        checkOutput("stk_gap_a_gnt", 32'(a_gnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 13'h0021, 8'h00, 1'b1, 1'b0, 13'h0031, 8'h00);
            checkOutput("stk_a_gnt", 32'(a_gnt), 32'(i < 4));
            checkOutput("stk_b_gnt", 32'(b_gnt), 32'(i == 4));
        end
        for (int i = 0; i < 4; i++) idle();

        // Random traffic; writes are withheld in the cycle just before a reset pulse.
        rst_next = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r, aq, aw, bq, bw;
            r        = rst_next;
            rst_next = ($urandom_range(199) == 0);
            aq       = ($urandom_range(99) < 65);
            bq       = ($urandom_range(99) < 55);
            aw       = !rst_next && ($urandom_range(1) == 1);
            bw       = !rst_next && ($urandom_range(1) == 1);
            applyStimulus(r, aq, aw, pickAddr(), DATA_W'($urandom), bq, bw, pickAddr(), DATA_W'($urandom));
        end
        for (int i = 0; i < 6; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cart_mem_arbiter.md
CART_MEM_ARBITER -- requirements
Module: cart_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, memory word address width; DATA_W, default 8, data width; MAX_A_BURST, default 4, consecutive A grants allowed while B waits.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  requester A (cartridge bus side) access request.
- a_write  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A request accepted this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_req, b_write, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same widths and meanings for requester B (SD loader / DMA).
- mem_address  out  ADDR_W  to memory port 2 address.
- mem_chipselect  out  1  to memory port 2 chipselect.
- mem_write  out  1  to memory port 2 write.
- mem_writedata  out  DATA_W  to memory port 2 writedata.
- mem_clken  out  1  to memory port 2 clock enable.
- mem_readdata  in  DATA_W  from memory port 2 readdata (valid one cycle after address is presented).
REQ-003 SHALL use one clock domain (clk); reset SHALL be synchronous and active-high.

Function
REQ-004 Grant SHALL be combinational in the request cycle N: at most one of a_gnt/b_gnt high; a_gnt only if a_req, b_gnt only if b_req; requester treats gnt as accept and may present its next access in N+1.
REQ-005 Default priority SHALL be A over B when both request.
REQ-006 A streak counter SHALL increment on each a_gnt issued while b_req is high, saturating at MAX_A_BURST.
REQ-007 When streak == MAX_A_BURST and b_req is high, B SHALL be granted that cycle regardless of a_req.
REQ-008 Streak SHALL clear to 0 on any b_gnt or on any cycle with b_req low.
REQ-009 Idle (no req) cycle SHALL produce no grant and leave streak per REQ-008.
REQ-010 Issue stage: at the end of grant cycle N, mem_address/mem_write/mem_writedata SHALL register the winner's fields and mem_chipselect SHALL register 1; with no grant, mem_chipselect SHALL register 0 and mem_write SHALL register 0.
REQ-011 mem_clken SHALL be 1 in every cycle after reset deassertion.
REQ-012 For a granted read, a 2-stage tag pipeline (valid, source) SHALL track it; mem_readdata SHALL be registered into the source's rdata at the end of N+2 and that source's rvalid SHALL be high for exactly cycle N+3.
REQ-013 Read latency SHALL be exactly 3 cycles (gnt cycle to rvalid cycle); throughput SHALL be one access per cycle, back-to-back across both requesters.
REQ-014 Granted writes SHALL produce no rvalid; a_rdata/b_rdata SHALL hold their last value when their rvalid is low.
REQ-015 a_rvalid and b_rvalid SHALL never be high in the same cycle.
REQ-016 Read-after-write to the same address from either requester SHALL return the written data when the read is granted at least one cycle after the write.

Reset
REQ-017 While reset is high: a_gnt, b_gnt = 0; mem_chipselect, mem_write, mem_clken = 0; mem_address, mem_writedata = 0; a_rvalid, b_rvalid = 0; a_rdata, b_rdata = 0; streak = 0; tag pipeline cleared.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight reads (no rvalid for them after reset) and SHALL cancel any write not yet registered to the memory port.
REQ-019 First grant SHALL be possible in the first cycle with reset low.

Verification
REQ-020 Single read: mem word 0x0123 = 0x5A, a_req read 0x0123 in cycle N -> a_gnt in N, mem_chipselect=1/mem_address=0x0123 in N+1, a_rvalid with a_rdata=0x5A in N+3 only.
REQ-021 Contention: a_req and b_req both held continuously -> grant pattern A,A,A,A,B repeating (MAX_A_BURST=4); never two grants per cycle.
REQ-022 Back-to-back mixed: B write 0x1FFF=0xC3 in N, A read 0x1FFF in N+1 -> a_rvalid in N+4 with 0xC3; b_rvalid never asserted.
REQ-023 Reset mid-flight: A reads granted in N and N+1, reset high in N+2 -> no a_rvalid in N+3/N+4; all outputs at REQ-017 values.
REQ-024 Streak clear: A granted 3 times with b_req high, b_req drops one cycle, then rises -> A receives 4 further grants before B.
REQ-025 Address boundary: reads to 0x0000 and 0x1FFF alternate between A and B every cycle -> each rvalid routed to the correct requester, 3-cycle latency, data matches preload.
